// File: rtl/ha_serial_accum.sv
// Bit-serial accumulator that finishes half-adder pairs into a WIDTH-bit word.
// Optional saturation on overflow: define HA_SERIAL_ACCUM_SAT_EN.
module ha_serial_accum #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             ha_sum,
  input  logic             ha_carry,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic             c, c_n;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] data_n;
  logic             carry_n;
  logic             valid_n;

  logic             s;
  logic             c_step;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] final_word;

  assign s       = ha_sum ^ c;
  assign c_step  = ha_carry | (ha_sum & c);
  assign shifted = {s, shreg[WIDTH-1:1]};

`ifdef HA_SERIAL_ACCUM_SAT_EN
  assign final_word = c_step ? '1 : shifted;
`else
  assign final_word = shifted;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      c             <= 1'b0;
      count         <= '0;
      shreg         <= '0;
      res_data      <= '0;
      res_carry_out <= 1'b0;
      res_valid     <= 1'b0;
    end else begin
      state         <= state_n;
      c             <= c_n;
      count         <= count_n;
      shreg         <= shreg_n;
      res_data      <= data_n;
      res_carry_out <= carry_n;
      res_valid     <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    c_n     = c;
    count_n = count;
    shreg_n = shreg;
    data_n  = res_data;
    carry_n = res_carry_out;
    valid_n = res_valid;
    if (ena) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_n = ACCUM;
            c_n     = 1'b0;
            count_n = '0;
            shreg_n = '0;
          end
        end
        ACCUM: begin
          // start wins over a bit presented in the same cycle
          if (start) begin
            c_n     = 1'b0;
            count_n = '0;
            shreg_n = '0;
          end else if (bit_valid) begin
            c_n     = c_step;
            shreg_n = shifted;
            if (count == LAST) begin
              state_n = HOLD;
              count_n = '0;
              data_n  = final_word;
              carry_n = c_step;
              valid_n = 1'b1;
            end else begin
              count_n = count + 1'b1;
            end
          end
        end
        HOLD: begin
          if (res_valid && res_ready) begin
            state_n = IDLE;
            valid_n = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
